uart_rx_autobaud: RTL and testbench

//   Autobaud controller that configures and sequences the UART receiver (UartRx).
//   - Measures a host-sent 0x55 sync character on the serial line and derives clock_divider (clocks per bit).
//   - Holds the receiver in reset until a valid divider is locked, then releases it with the measured value.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_edge.sv | 25 ++
 rtl/uart_rx_autobaud.sv | 155 +++++++++++++++
 tb/tb_uart_rx_autobaud.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM states and widths common with the receiver.
package uart_pkg;

    localparam int SYNC_EDGES    = 5;
    localparam int DIVIDER_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        SETTLE,
        LOCKED,
        ERROR
    } autobaud_state_t;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for an asynchronous line, with a registered falling-edge pulse.
// The level output is delayed to line up with the pulse: when fall=1, level=0.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= 3'b111;
            fall <= 1'b0;
        end else begin
            sh   <= {sh[1:0], din};
            fall <= sh[2] & ~sh[1];
        end
    end

    assign level = sh[2];

endmodule

// File: rtl/uart_rx_autobaud.sv
// Autobaud controller: measures a 0x55 sync character and releases UartRx with the derived divider.
module uart_rx_autobaud
    import uart_pkg::*;
#(
    parameter int COUNT_WIDTH     = 20,
    parameter int DEFAULT_DIVIDER = 16,
    parameter int MIN_DIVIDER     = 2,
    parameter int IDLE_CLOCKS     = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic                     serial_i,
    output logic [DIVIDER_WIDTH-1:0] clock_divider_o,
    output logic                     uart_reset_o,
    output logic                     busy_o,
    output logic                     locked_o,
    output logic                     error_o
);

    localparam int TW = COUNT_WIDTH + 2;
    localparam int RW = COUNT_WIDTH + 3;
    localparam int WW = COUNT_WIDTH + 19;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic line, fall;

    uart_sync_edge u_sync (
        .clk   (clock_i),
        .rst_n (reset_ni),
        .din   (serial_i),
        .level (line),
        .fall  (fall)
    );

    autobaud_state_t          state_q, state_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]   run_q, run_d;
    logic [COUNT_WIDTH-1:0]   ref_q, ref_d;
    logic [TW-1:0]            total_q, total_d;
    logic [2:0]               edge_q, edge_d;
    logic [DIVIDER_WIDTH-1:0] meas_q, meas_d;
    logic [DIVIDER_WIDTH-1:0] div_q, div_d;

    // cnt holds cycles elapsed since the last restart, so on a falling edge it is the interval itself
    logic [TW-1:0]            tot_next;
    logic [RW-1:0]            rnd;
    logic [WW-1:0]            wide;
    logic [DIVIDER_WIDTH-1:0] div_calc;
    logic [COUNT_WIDTH-1:0]   diff;
    logic                     tol_bad, idle_done, settle_done;

    assign tot_next    = total_q + TW'(cnt_q);
    assign rnd         = RW'(tot_next) + RW'(4);
    assign wide        = WW'(rnd) >> 3;
    assign div_calc    = (|wide[WW-1:DIVIDER_WIDTH]) ? '1 : wide[DIVIDER_WIDTH-1:0];
    assign diff        = (cnt_q > ref_q) ? cnt_q - ref_q : ref_q - cnt_q;
    assign tol_bad     = diff > (ref_q >> 2);
    assign idle_done   = line && (32'(run_q) + 32'd1 >= 32'(IDLE_CLOCKS));
    assign settle_done = line && (32'(run_q) + 32'd1 >= 32'(meas_q));

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            ref_q   <= '0;
            total_q <= '0;
            edge_q  <= '0;
            meas_q  <= DIVIDER_WIDTH'(DEFAULT_DIVIDER);
            div_q   <= DIVIDER_WIDTH'(DEFAULT_DIVIDER);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            ref_q   <= ref_d;
            total_q <= total_d;
            edge_q  <= edge_d;
            meas_q  <= meas_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        ref_d   = ref_q;
        total_d = total_q;
        edge_d  = edge_q;
        meas_d  = meas_q;
        div_d   = div_q;
        case (state_q)
            IDLE, LOCKED, ERROR: begin
                if (start_i) begin
                    state_d = WAIT_IDLE;
                    run_d   = '0;
                end
            end
            WAIT_IDLE: begin
                run_d = line ? run_q + 1'b1 : '0;
                if (idle_done) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (fall) begin
                    state_d = MEASURE;
                    cnt_d   = COUNT_WIDTH'(1);
                    total_d = '0;
                    edge_d  = 3'd1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    if (edge_q != 3'd1 && tol_bad) begin
                        state_d = ERROR;
                    end else if (edge_q == 3'(SYNC_EDGES - 1)) begin
                        meas_d  = div_calc;
                        cnt_d   = COUNT_WIDTH'(1);
                        run_d   = '0;
                        state_d = (div_calc < DIVIDER_WIDTH'(MIN_DIVIDER)) ? ERROR : SETTLE;
                    end else begin
                        if (edge_q == 3'd1) ref_d = cnt_q;
                        total_d = tot_next;
                        cnt_d   = COUNT_WIDTH'(1);
                        edge_d  = edge_q + 3'd1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                // high-run count restarts whenever the line is low, which covers any falling edge
                run_d = line ? run_q + 1'b1 : '0;
                if (settle_done) begin
                    state_d = LOCKED;
                    div_d   = meas_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clock_divider_o = div_q;
    assign uart_reset_o    = (state_q != LOCKED);
    assign busy_o          = (state_q inside {WAIT_IDLE, WAIT_START, MEASURE, SETTLE});
    assign locked_o        = (state_q == LOCKED);
    assign error_o         = (state_q == ERROR);

endmodule

// File: tb/tb_uart_rx_autobaud.sv
// Directed bench for the autobaud controller: lock, jitter, tolerance, timeout, restart and reset cases.
module tb_uart_rx_autobaud;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        serial = 1'b1;
    logic [15:0] div;
    logic        ur, busy, locked, err;

    logic        start2 = 1'b0;
    logic        serial2 = 1'b1;
    logic [15:0] div2;
    logic        ur2, busy2, locked2, err2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_autobaud dut (
        .clock_i         (clk),
        .reset_ni        (rst_n),
        .start_i         (start),
        .serial_i        (serial),
        .clock_divider_o (div),
        .uart_reset_o    (ur),
        .busy_o          (busy),
        .locked_o        (locked),
        .error_o         (err)
    );

    uart_rx_autobaud #(.COUNT_WIDTH(8)) dut8 (
        .clock_i         (clk),
        .reset_ni        (rst_n),
        .start_i         (start2),
        .serial_i        (serial2),
        .clock_divider_o (div2),
        .uart_reset_o    (ur2),
        .busy_o          (busy2),
        .locked_o        (locked2),
        .error_o         (err2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0][7:0] uni(input int n);
        logic [8:0][7:0] l;
        for (int i = 0; i < 9; i++) l[i] = 8'(n);
        return l;
    endfunction

    // start bit plus 8 data bits, each segment lens[s] clocks; optional start_i pulse at a segment
    task automatic send_frame(input logic [7:0] data, input logic [8:0][7:0] lens, input int pulse_seg);
        logic [8:0] bits;
        bits = {data, 1'b0};
        for (int s = 0; s < 9; s++) begin
            serial = bits[s];
            for (int c = 0; c < int'(lens[s]); c++) begin
                start = (s == pulse_seg) && (c == 0);
                tick(1);
            end
        end
        start  = 1'b0;
        serial = 1'b1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_chk++; if (div !== 16'd16) begin n_bad++; $display("FAIL reset_div got=%0d want=16", div); end
        n_chk++; if (ur !== 1'b1) begin n_bad++; $display("FAIL reset_uart_reset got=%0b want=1", ur); end
        n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        n_chk++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
        n_chk++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%0b want=0", err); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start got=%0b want=1", busy); end
        tick(20);
        send_frame(8'h55, uni(16), -1);
        tick(18);
        n_chk++; if (locked !== 1'b0) begin n_bad++; $display("FAIL basic_locked_early got=%0b want=0", locked); end
        n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_settle got=%0b want=1", busy); end
        tick(1);
        n_chk++; if (locked !== 1'b1) begin n_bad++; $display("FAIL basic_locked got=%0b want=1", locked); end
        n_chk++; if (ur !== 1'b0) begin n_bad++; $display("FAIL basic_uart_reset got=%0b want=0", ur); end
        n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got=%0b want=0", busy); end
        n_chk++; if (div !== 16'd16) begin n_bad++; $display("FAIL basic_div got=%0d want=16", div); end
    endtask

    task automatic test_jitter();
        logic [8:0][7:0] l;
        l = uni(16);
        l[1] = 8'd15;
        l[2] = 8'd17;
        l[6] = 8'd17;
        arm();
        send_frame(8'h55, l, -1);
        tick(40);
        n_chk++; if (locked !== 1'b1) begin n_bad++; $display("FAIL jitter_locked got=%0b want=1", locked); end
        n_chk++; if (div !== 16'd16) begin n_bad++; $display("FAIL jitter_div got=%0d want=16", div); end
    endtask

    task automatic test_bad_sync();
        arm();
        serial = 1'b0; tick(16);
        serial = 1'b1; tick(16);
        serial = 1'b0; tick(32);
        serial = 1'b1; tick(32);
        serial = 1'b0;
        tick(3);
        n_chk++; if (err !== 1'b0) begin n_bad++; $display("FAIL badsync_err_early got=%0b want=0", err); end
        n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL badsync_busy got=%0b want=1", busy); end
        tick(1);
        n_chk++; if (err !== 1'b1) begin n_bad++; $display("FAIL badsync_err got=%0b want=1", err); end
        n_chk++; if (locked !== 1'b0) begin n_bad++; $display("FAIL badsync_locked got=%0b want=0", locked); end
        n_chk++; if (ur !== 1'b1) begin n_bad++; $display("FAIL badsync_uart_reset got=%0b want=1", ur); end
        n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badsync_busy_end got=%0b want=0", busy); end
        tick(12);
        serial = 1'b1; tick(16);
        serial = 1'b0; tick(16);
        serial = 1'b1; tick(20);
        n_chk++; if (err !== 1'b1) begin n_bad++; $display("FAIL badsync_err_sticky got=%0b want=1", err); end
        n_chk++; if (div !== 16'd16) begin n_bad++; $display("FAIL badsync_div got=%0d want=16", div); end
    endtask

    task automatic test_mid_start();
        arm();
        send_frame(8'h55, uni(16), 5);
        tick(40);
        n_chk++; if (locked !== 1'b1) begin n_bad++; $display("FAIL midstart_locked got=%0b want=1", locked); end
        n_chk++; if (err !== 1'b0) begin n_bad++; $display("FAIL midstart_err got=%0b want=0", err); end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_chk++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_locked got=%0b want=0", locked); end
        n_chk++; if (ur !== 1'b1) begin n_bad++; $display("FAIL relock_uart_reset got=%0b want=1", ur); end
        n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL relock_busy got=%0b want=1", busy); end
        n_chk++; if (div !== 16'd16) begin n_bad++; $display("FAIL relock_div got=%0d want=16", div); end
    endtask

    task automatic test_tolerance();
        logic [8:0][7:0] l;
        // I2 = 40 against I1 = 32: difference 8 is exactly the allowance; total 136 -> (140)>>3 = 17
        l = uni(16);
        l[2] = 8'd20;
        l[3] = 8'd20;
        arm();
        send_frame(8'h55, l, -1);
        tick(45);
        n_chk++; if (locked !== 1'b1) begin n_bad++; $display("FAIL tol_edge_locked got=%0b want=1", locked); end
        n_chk++; if (div !== 16'd17) begin n_bad++; $display("FAIL tol_edge_div got=%0d want=17", div); end
        l[3] = 8'd21;
        arm();
        send_frame(8'h55, l, -1);
        tick(30);
        n_chk++; if (err !== 1'b1) begin n_bad++; $display("FAIL tol_over_err got=%0b want=1", err); end
        n_chk++; if (locked !== 1'b0) begin n_bad++; $display("FAIL tol_over_locked got=%0b want=0", locked); end
        n_chk++; if (div !== 16'd17) begin n_bad++; $display("FAIL tol_over_div got=%0d want=17", div); end
    endtask

    task automatic test_reset_mid();
        arm();
        serial = 1'b0; tick(16);
        serial = 1'b1; tick(8);
        n_chk++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got=%0b want=1", busy); end
        #3 rst_n = 1'b0;
        #1;
        n_chk++; if (div !== 16'd16) begin n_bad++; $display("FAIL rstmid_div got=%0d want=16", div); end
        n_chk++; if (ur !== 1'b1) begin n_bad++; $display("FAIL rstmid_uart_reset got=%0b want=1", ur); end
        n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
        n_chk++; if (err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got=%0b want=0", err); end
        #2 rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_fast();
        arm();
        send_frame(8'h55, uni(4), -1);
        tick(20);
        n_chk++; if (locked !== 1'b1) begin n_bad++; $display("FAIL fast_locked got=%0b want=1", locked); end
        n_chk++; if (div !== 16'd4) begin n_bad++; $display("FAIL fast_div got=%0d want=4", div); end
        n_chk++; if (ur !== 1'b0) begin n_bad++; $display("FAIL fast_uart_reset got=%0b want=0", ur); end
        // 1 clk/bit measures div = (8+4)>>3 = 1, below the minimum
        arm();
        send_frame(8'h55, uni(1), -1);
        tick(20);
        n_chk++; if (err !== 1'b1) begin n_bad++; $display("FAIL mindiv_err got=%0b want=1", err); end
        n_chk++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mindiv_locked got=%0b want=0", locked); end
        n_chk++; if (div !== 16'd4) begin n_bad++; $display("FAIL mindiv_div got=%0d want=4", div); end
    endtask

    task automatic test_timeout();
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(20);
        serial2 = 1'b0;
        tick(258);
        n_chk++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL timeout_err_early got=%0b want=0", err2); end
        n_chk++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL timeout_busy_early got=%0b want=1", busy2); end
        tick(1);
        n_chk++; if (err2 !== 1'b1) begin n_bad++; $display("FAIL timeout_err got=%0b want=1", err2); end
        n_chk++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL timeout_busy got=%0b want=0", busy2); end
        n_chk++; if (ur2 !== 1'b1) begin n_bad++; $display("FAIL timeout_uart_reset got=%0b want=1", ur2); end
        n_chk++; if (div2 !== 16'd16) begin n_bad++; $display("FAIL timeout_div got=%0d want=16", div2); end
        serial2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jitter();
        test_bad_sync();
        test_mid_start();
        test_tolerance();
        test_reset_mid();
        test_fast();
        test_timeout();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
